branch_history_register: RTL

//  Speculative global branch-history register with an in-order checkpoint queue. Sits directly upstream
//  of pattern_history_table: drives its read index (his_index) at fetch and its update port
//  (update_en / his_index / real_br_taken) at branch resolution. Repairs the speculative history and

---
 rtl/bp_pkg.sv | 11 +
 rtl/branch_history_register_if.sv | 29 ++
 rtl/bhr_ckpt_fifo.sv | 40 ++++
 rtl/branch_history_register.sv | 64 ++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: branch-predictor shared sizing and checkpoint entry layout.
// Used by branch_history_register, pattern_history_table and the fetch stage.
package bp_pkg;
    localparam int HIST_W  = 4;
    localparam int DEPTH   = 4;
    localparam int ENTRY_W = HIST_W + 1;
    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              pred;
    } entry_t;
endpackage

// File: rtl/branch_history_register_if.sv
// branch_history_register_if: fetch/resolve/PHT-update signals of the history register.
// BHR_STATS_EN adds the resolved-branch and mispredict counters.
interface branch_history_register_if #(parameter int HIST_W = bp_pkg::HIST_W);
    logic              pred_valid;
    logic              pred_taken;
    logic              res_valid;
    logic              res_taken;
    logic [HIST_W-1:0] his_index;
    logic              full;
    logic              upd_en;
    logic [HIST_W-1:0] upd_index;
    logic              upd_taken;
    logic              mispredict;
`ifdef BHR_STATS_EN
    logic [31:0]       stat_br_cnt;
    logic [31:0]       stat_mp_cnt;
    modport master (output pred_valid, pred_taken, res_valid, res_taken,
                    input  his_index, full, upd_en, upd_index, upd_taken, mispredict,
                           stat_br_cnt, stat_mp_cnt);
    modport slave  (input  pred_valid, pred_taken, res_valid, res_taken,
                    output his_index, full, upd_en, upd_index, upd_taken, mispredict,
                           stat_br_cnt, stat_mp_cnt);
`else
    modport master (output pred_valid, pred_taken, res_valid, res_taken,
                    input  his_index, full, upd_en, upd_index, upd_taken, mispredict);
    modport slave  (input  pred_valid, pred_taken, res_valid, res_taken,
                    output his_index, full, upd_en, upd_index, upd_taken, mispredict);
`endif
endinterface

// File: rtl/bhr_ckpt_fifo.sv
// bhr_ckpt_fifo: in-order checkpoint queue of {history, prediction} per in-flight branch.
// Flush drops every entry at once by snapping the read pointer onto the write pointer.
module bhr_ckpt_fifo #(
    parameter int W     = bp_pkg::ENTRY_W,
    parameter int DEPTH = bp_pkg::DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= r_wr;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(i_push);
            r_rd  <= r_rd + AW'(i_pop);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr] <= i_din;
    assign o_dout  = r_mem[r_rd];
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
endmodule

// File: rtl/branch_history_register.sv
// branch_history_register: speculative global history with checkpoint repair and PHT update port.
// Define BHR_STATS_EN for saturating resolved-branch / mispredict counters.
module branch_history_register #(
    parameter int HIST_W = bp_pkg::HIST_W,
    parameter int DEPTH  = bp_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_history_register_if.slave  bus
);
    logic [HIST_W:0]   w_head;
    logic              w_full, w_empty, w_push, w_pop, w_mp;
    logic [HIST_W-1:0] r_spec, r_upd_index;
    logic              r_upd_en, r_upd_taken, r_mp;
    assign w_pop  = bus.res_valid & ~w_empty;
    assign w_mp   = w_pop & (bus.res_taken ^ w_head[0]);
    assign w_push = bus.pred_valid & ~w_full & ~w_mp;
    bhr_ckpt_fifo #(.W(HIST_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_mp),
        .i_din   ({r_spec, bus.pred_taken}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // A mispredict rebuilds history from the checkpoint plus the real outcome
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_spec      <= '0;
            r_upd_en    <= 1'b0;
            r_upd_index <= '0;
            r_upd_taken <= 1'b0;
            r_mp        <= 1'b0;
        end else begin
            r_spec      <= w_mp ? {w_head[HIST_W-1:1], bus.res_taken}
                         : w_push ? {r_spec[HIST_W-2:0], bus.pred_taken} : r_spec;
            r_upd_en    <= w_pop;
            r_upd_index <= w_pop ? w_head[HIST_W:1] : r_upd_index;
            r_upd_taken <= w_pop ? bus.res_taken : r_upd_taken;
            r_mp        <= w_mp;
        end
    assign bus.his_index  = r_spec;
    assign bus.full       = w_full;
    assign bus.upd_en     = r_upd_en;
    assign bus.upd_index  = r_upd_index;
    assign bus.upd_taken  = r_upd_taken;
    assign bus.mispredict = r_mp;
`ifdef BHR_STATS_EN
    logic [31:0] r_br_cnt, r_mp_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else begin
            r_br_cnt <= (w_pop && r_br_cnt != '1) ? r_br_cnt + 32'd1 : r_br_cnt;
            r_mp_cnt <= (w_mp && r_mp_cnt != '1) ? r_mp_cnt + 32'd1 : r_mp_cnt;
        end
    assign bus.stat_br_cnt = r_br_cnt;
    assign bus.stat_mp_cnt = r_mp_cnt;
`endif
endmodule
